// File: rtl/sli_rst_seq_pkg.sv
// rtl/sli_rst_seq_pkg.sv - shared types and helpers for the sli_rst_seq reset sequencer
// Contents: sequencer state enum, timer width helper, channel count limit.
package sli_rst_seq_pkg;

  localparam int MAX_CH = 32;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RELEASE   = 2'd1,
    DONE      = 2'd2,
    SW_ASSERT = 2'd3
  } state_e;

  // Timer must hold the larger of the two load values.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sli_rst_seq_timer.sv
// rtl/sli_rst_seq_timer.sv - loadable down-counter shared by hold and gap timing
// Ports:
//   clk, nreset   clock and synchronous active-low reset (counter resets to RST_VAL)
//   load/load_val reload the counter on this edge (takes priority over counting)
//   en            count down while nonzero
//   expire        high for the enabled cycle in which the counter sits at zero
module sli_rst_seq_timer #(
  parameter int           W       = 5,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/sli_rst_seq.sv
// rtl/sli_rst_seq.sv - per-domain reset sequencer with software reset handshake
// Releases NUM_CH active-low resets in ascending order after HOLD_CYCLES, spaced
// by GAP_CYCLES. A four-phase sw_rst_req/sw_rst_ack handshake re-runs the sequence.
// Optional macro SLI_RST_SEQ_REVERSE_ASSERT_EN: software reset asserts channels in
// descending order, GAP_CYCLES apart, instead of all at once.
// Ports:
//   clk         sole clock
//   nreset      global synchronous active-low reset
//   sw_rst_req  software reset request (level)
//   sw_rst_ack  software reset acknowledge (level, registered)
//   ch_nreset   per-channel active-low resets (registered)
//   seq_done    high while all channels are released
//   busy        high while a hold/release/assert sequence runs
module sli_rst_seq
  import sli_rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              sw_rst_req,
  output logic              sw_rst_ack,
  output logic [NUM_CH-1:0] ch_nreset,
  output logic              seq_done,
  output logic              busy
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // After global reset the first edge with nreset=1 is the first hold cycle, so
  // the reset edge loads the full count. A software accept edge is itself that
  // first hold cycle, hence one less. A gap load on a release edge counts the
  // following GAP_CYCLES edges, the last of which releases the next channel.
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              act_q, act_d;    // accepted software request awaiting ack
  logic              finish;
  logic              t_load, t_en, t_expire;
  logic [CW-1:0]     t_val;

  sli_rst_seq_timer #(
    .W       (CW),
    .RST_VAL (HOLD_LOAD)
  ) u_timer (
    .clk      (clk),
    .nreset   (nreset),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .expire   (t_expire)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= HOLD;
      idx_q   <= '0;
      ch_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      act_q   <= act_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    done_d  = done_q;
    busy_d  = busy_q;
    ack_d   = ack_q;
    act_d   = act_q;
    finish  = 1'b0;
    t_load  = 1'b0;
    t_en    = 1'b0;
    t_val   = GAP_LOAD;

    if (ack_q && !sw_rst_req) begin
      ack_d = 1'b0;
    end

    case (state_q)
      HOLD: begin
        t_en = 1'b1;
        if (t_expire) begin
          ch_d[0] = 1'b1;
          if (NUM_CH == 1) begin
            finish = 1'b1;
          end else begin
            state_d = RELEASE;
            idx_d   = IW'(1);
            t_load  = 1'b1;
            t_val   = GAP_LOAD;
          end
        end
      end

      RELEASE: begin
        t_en = 1'b1;
        if (t_expire) begin
          ch_d[idx_q] = 1'b1;
          if (idx_q == LAST_IDX) begin
            finish = 1'b1;
          end else begin
            idx_d  = idx_q + IW'(1);
            t_load = 1'b1;
            t_val  = GAP_LOAD;
          end
        end
      end

      DONE: begin
        // A raised ack blocks re-acceptance until the requester drops req.
        if (sw_rst_req && !ack_q) begin
          act_d  = 1'b1;
          done_d = 1'b0;
          busy_d = 1'b1;
          t_load = 1'b1;
`ifdef SLI_RST_SEQ_REVERSE_ASSERT_EN
          ch_d[NUM_CH-1] = 1'b0;
          if (NUM_CH == 1) begin
            state_d = HOLD;
            idx_d   = '0;
            t_val   = HOLD_RELOAD;
          end else begin
            state_d = SW_ASSERT;
            idx_d   = IW'(NUM_CH - 2);
            t_val   = GAP_LOAD;
          end
`else
          ch_d    = '0;
          state_d = HOLD;
          idx_d   = '0;
          t_val   = HOLD_RELOAD;
`endif
        end
      end

`ifdef SLI_RST_SEQ_REVERSE_ASSERT_EN
      SW_ASSERT: begin
        t_en = 1'b1;
        if (t_expire) begin
          ch_d[idx_q] = 1'b0;
          t_load      = 1'b1;
          if (idx_q == '0) begin
            state_d = HOLD;
            t_val   = HOLD_RELOAD;
          end else begin
            idx_d = idx_q - IW'(1);
            t_val = GAP_LOAD;
          end
        end
      end
`endif

      default: begin
        // Unreachable encoding: restart the hold phase with all channels held.
        state_d = HOLD;
        idx_d   = '0;
        ch_d    = '0;
        done_d  = 1'b0;
        busy_d  = 1'b1;
        t_load  = 1'b1;
        t_val   = HOLD_RELOAD;
      end
    endcase

    // Last channel released: report completion and answer any pending request.
    if (finish) begin
      state_d = DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      if (act_q) begin
        ack_d = 1'b1;
        act_d = 1'b0;
      end
    end
  end

  assign ch_nreset  = ch_q;
  assign seq_done   = done_q;
  assign busy       = busy_q;
  assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_sli_rst_seq.sv
// tb/tb_sli_rst_seq.sv - scoreboard testbench for sli_rst_seq
module tb_sli_rst_seq;

  typedef struct {
    int         cyc;
    logic [6:0] v;      // {seq_done, busy, sw_rst_ack, ch_nreset[3:0]}
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       req = 1'b0;
  logic       ack;
  logic [3:0] ch;
  logic       done, busy;
  logic       nreset1 = 1'b0;
  logic       req1 = 1'b0;
  logic       ack1;
  logic [0:0] ch1;
  logic       done1, busy1;
  logic [6:0] obs, obs1;

  int   edge_n = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  exp_t e;

  sli_rst_seq #(.NUM_CH(4), .HOLD_CYCLES(16), .GAP_CYCLES(4)) dut (
    .clk(clk), .nreset(nreset), .sw_rst_req(req), .sw_rst_ack(ack),
    .ch_nreset(ch), .seq_done(done), .busy(busy)
  );

  sli_rst_seq #(.NUM_CH(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .nreset(nreset1), .sw_rst_req(req1), .sw_rst_ack(ack1),
    .ch_nreset(ch1), .seq_done(done1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n = edge_n + 1;

  assign obs  = {done, busy, ack, ch};
  assign obs1 = {done1, busy1, ack1, 3'b000, ch1};

  function automatic void push(input int c, input logic [6:0] v, input string tag);
    exp_t x;
    x.cyc = c; x.v = v; x.tag = tag;
    exp_q.push_back(x);
  endfunction

  task automatic test_reset();
    int base;
    nreset = 1'b0; nreset1 = 1'b0; req = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (obs !== 7'b010_0000) begin
      miscompares++;
      $display("FAIL reset_state got %b want %b", obs, 7'b010_0000);
    end
    vectors++;
    if (obs1 !== 7'b010_0000) begin
      miscompares++;
      $display("FAIL reset_state_ch1 got %b want %b", obs1, 7'b010_0000);
    end
    nreset = 1'b1;
    base = edge_n + 1;
    push(base + 15, 7'b010_0000, "por_hold_end");
    push(base + 16, 7'b010_0001, "por_ch0");
    push(base + 19, 7'b010_0001, "por_gap0");
    push(base + 20, 7'b010_0011, "por_ch1");
    push(base + 24, 7'b010_0111, "por_ch2");
    push(base + 27, 7'b010_0111, "por_gap2");
    push(base + 28, 7'b100_1111, "por_done");
    push(base + 30, 7'b100_1111, "por_stable");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
        e = exp_q.pop_front();
        vectors++;
        if (e.cyc != edge_n || obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cycle %0d got %b want %b at cycle %0d", e.tag, edge_n, obs, e.v, e.cyc);
        end
      end
    end
  endtask

  task automatic test_single_channel();
    int b;
    nreset1 = 1'b1;
    b = edge_n + 1;
    push(b,     7'b010_0000, "one_ch_hold");
    push(b + 1, 7'b100_0001, "one_ch_done");
    push(b + 3, 7'b100_0001, "one_ch_stable");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
        e = exp_q.pop_front();
        vectors++;
        if (e.cyc != edge_n || obs1 !== e.v) begin
          miscompares++;
          $display("FAIL %s cycle %0d got %b want %b at cycle %0d", e.tag, edge_n, obs1, e.v, e.cyc);
        end
      end
    end
  endtask

  task automatic test_sw_reset();
    int a, d;
    req = 1'b1;
    a = edge_n;
`ifdef SLI_RST_SEQ_REVERSE_ASSERT_EN
    push(a + 1,  7'b010_0111, "sw_ch3_fall");
    push(a + 4,  7'b010_0111, "sw_gap3");
    push(a + 5,  7'b010_0011, "sw_ch2_fall");
    push(a + 9,  7'b010_0001, "sw_ch1_fall");
    push(a + 13, 7'b010_0000, "sw_ch0_fall");
    push(a + 28, 7'b010_0000, "sw_hold_end");
    push(a + 29, 7'b010_0001, "sw_ch0");
    push(a + 33, 7'b010_0011, "sw_ch1");
    push(a + 37, 7'b010_0111, "sw_ch2");
    push(a + 40, 7'b010_0111, "sw_gap2");
    push(a + 41, 7'b101_1111, "sw_ack");
    push(a + 44, 7'b101_1111, "sw_no_retrigger");
`else
    push(a + 1,  7'b010_0000, "sw_assert_all");
    push(a + 16, 7'b010_0000, "sw_hold_end");
    push(a + 17, 7'b010_0001, "sw_ch0");
    push(a + 20, 7'b010_0001, "sw_gap0");
    push(a + 21, 7'b010_0011, "sw_ch1");
    push(a + 25, 7'b010_0111, "sw_ch2");
    push(a + 28, 7'b010_0111, "sw_gap2");
    push(a + 29, 7'b101_1111, "sw_ack");
    push(a + 32, 7'b101_1111, "sw_no_retrigger");
`endif
    while (exp_q.size() > 0) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
        e = exp_q.pop_front();
        vectors++;
        if (e.cyc != edge_n || obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cycle %0d got %b want %b at cycle %0d", e.tag, edge_n, obs, e.v, e.cyc);
        end
      end
    end
    req = 1'b0;
    d = edge_n;
    push(d + 1, 7'b100_1111, "sw_ack_clear");
    push(d + 3, 7'b100_1111, "sw_idle");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
        e = exp_q.pop_front();
        vectors++;
        if (e.cyc != edge_n || obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cycle %0d got %b want %b at cycle %0d", e.tag, edge_n, obs, e.v, e.cyc);
        end
      end
    end
  endtask

  task automatic test_abort();
    int a, b;
    req = 1'b1;
    a = edge_n;
`ifdef SLI_RST_SEQ_REVERSE_ASSERT_EN
    push(a + 1,  7'b010_0111, "abort_accept");
    push(a + 20, 7'b010_0000, "abort_pre");
`else
    push(a + 1,  7'b010_0000, "abort_accept");
    push(a + 20, 7'b010_0001, "abort_pre");
`endif
    while (exp_q.size() > 0) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
        e = exp_q.pop_front();
        vectors++;
        if (e.cyc != edge_n || obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cycle %0d got %b want %b at cycle %0d", e.tag, edge_n, obs, e.v, e.cyc);
        end
      end
    end
    nreset = 1'b0;
    req = 1'b0;
    push(edge_n + 1, 7'b010_0000, "abort_reset_vals");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
        e = exp_q.pop_front();
        vectors++;
        if (e.cyc != edge_n || obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cycle %0d got %b want %b at cycle %0d", e.tag, edge_n, obs, e.v, e.cyc);
        end
      end
    end
    nreset = 1'b1;
    b = edge_n + 1;
    push(b + 15, 7'b010_0000, "abort_hold_end");
    push(b + 16, 7'b010_0001, "abort_ch0");
    push(b + 20, 7'b010_0011, "abort_ch1");
    push(b + 24, 7'b010_0111, "abort_ch2");
    push(b + 28, 7'b100_1111, "abort_done_no_ack");
    push(b + 30, 7'b100_1111, "abort_lost_req");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
        e = exp_q.pop_front();
        vectors++;
        if (e.cyc != edge_n || obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cycle %0d got %b want %b at cycle %0d", e.tag, edge_n, obs, e.v, e.cyc);
        end
      end
    end
  endtask

  task automatic test_req_during_seq();
    int base;
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    base = edge_n + 1;
    push(base + 2, 7'b010_0000, "early_pre_req");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
        e = exp_q.pop_front();
        vectors++;
        if (e.cyc != edge_n || obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cycle %0d got %b want %b at cycle %0d", e.tag, edge_n, obs, e.v, e.cyc);
        end
      end
    end
    req = 1'b1;
    push(base + 27, 7'b010_0111, "early_ignored");
    push(base + 28, 7'b100_1111, "early_done");
`ifdef SLI_RST_SEQ_REVERSE_ASSERT_EN
    push(base + 29, 7'b010_0111, "early_accept");
    push(base + 41, 7'b010_0000, "early_ch0_fall");
    push(base + 57, 7'b010_0001, "early_ch0");
    push(base + 69, 7'b101_1111, "early_ack");
    push(base + 70, 7'b101_1111, "early_ack_hold");
`else
    push(base + 29, 7'b010_0000, "early_accept");
    push(base + 45, 7'b010_0001, "early_ch0");
    push(base + 57, 7'b101_1111, "early_ack");
    push(base + 58, 7'b101_1111, "early_ack_hold");
`endif
    while (exp_q.size() > 0) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
        e = exp_q.pop_front();
        vectors++;
        if (e.cyc != edge_n || obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cycle %0d got %b want %b at cycle %0d", e.tag, edge_n, obs, e.v, e.cyc);
        end
      end
    end
    req = 1'b0;
    push(edge_n + 1, 7'b100_1111, "early_ack_clear");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
        e = exp_q.pop_front();
        vectors++;
        if (e.cyc != edge_n || obs !== e.v) begin
          miscompares++;
          $display("FAIL %s cycle %0d got %b want %b at cycle %0d", e.tag, edge_n, obs, e.v, e.cyc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_sw_reset();
    test_abort();
    test_req_during_seq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
